// File: rtl/wb_pkg.sv
// Shared types and constants for the write-back port arbiter.
package wb_pkg;

  localparam int unsigned RD_W             = 6;
  localparam int unsigned ADDR_W           = 5;
  localparam int unsigned DATA_W           = 32;
  localparam int unsigned FLOAT_SEL_BIT    = 5;
  localparam int unsigned LU_DEPTH_DEF     = 2;
  localparam int unsigned STARVE_LIMIT_DEF = 4;

  typedef struct packed {
    logic [RD_W-1:0]   rd;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  // Integer x0 is hardwired; the float file has a real f0.
  function automatic logic is_int_zero(input logic [RD_W-1:0] rd);
    return (rd[FLOAT_SEL_BIT] == 1'b0) && (rd[ADDR_W-1:0] == '0);
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Long-latency result FIFO; a push into a full FIFO is accepted only alongside a pop.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = LU_DEPTH_DEF
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push,
  input  wb_req_t din,
  input  logic    pop,
  output wb_req_t head,
  output logic    full,
  output logic    empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  wb_req_t          mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between the pipeline and a long-latency unit,
// and tracks outstanding long-latency destinations for decode hazard stalls.
module wb_port_arbiter
  import wb_pkg::*;
#(
  parameter int unsigned LU_DEPTH     = LU_DEPTH_DEF,
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_en_wb,
  input  logic              float_wb_en_wb,
  input  logic [RD_W-1:0]   rd_addr_wb,
  input  logic [DATA_W-1:0] wb_data_wb,
  input  logic              lu_valid,
  input  logic [RD_W-1:0]   lu_rd,
  input  logic [DATA_W-1:0] lu_data,
  output logic              lu_ready,
  input  logic              lu_issue,
  input  logic [RD_W-1:0]   lu_issue_rd,
  input  logic [RD_W-1:0]   id_rs1,
  input  logic [RD_W-1:0]   id_rs2,
  input  logic [RD_W-1:0]   id_rs3,
  input  logic [RD_W-1:0]   id_rd,
  output logic              sb_stall,
  output logic              pipe_hold,
  output logic              rf_we,
  output logic              frf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata
);

  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned NREGS = 1 << RD_W;

  logic             pipe_req;
  logic             sel_pipe;
  logic             sel_fifo;
  logic             sel_byp;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  wb_req_t          fifo_head;
  wb_req_t          lu_req;
  wb_req_t          grant_req;
  logic             clr_en;
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_nxt;
  logic [CNT_W-1:0] starve_cnt;
  logic [CNT_W-1:0] starve_nxt;

  assign pipe_req = wb_en_wb || float_wb_en_wb;
  assign lu_req   = '{rd: lu_rd, data: lu_data};
  assign lu_ready = !fifo_full;
  // A result arriving during reset is discarded rather than bypassed.
  assign push     = lu_valid && !sel_byp && !rst;

  // Port grant priority: held FIFO, pipeline, FIFO backlog, direct bypass.
  always_comb begin
    sel_pipe = 1'b0;
    sel_fifo = 1'b0;
    sel_byp  = 1'b0;
    if (pipe_hold) begin
      sel_fifo = 1'b1;
    end else if (pipe_req) begin
      sel_pipe = 1'b1;
    end else if (!fifo_empty) begin
      sel_fifo = 1'b1;
    end else if (lu_valid && !rst) begin
      sel_byp = 1'b1;
    end
  end

  always_comb begin
    rf_we     = 1'b0;
    frf_we    = 1'b0;
    rf_waddr  = '0;
    rf_wdata  = '0;
    clr_en    = 1'b0;
    grant_req = sel_fifo ? fifo_head : lu_req;
    if (sel_pipe) begin
      rf_we    = wb_en_wb && !is_int_zero(rd_addr_wb) && !rd_addr_wb[FLOAT_SEL_BIT];
      frf_we   = float_wb_en_wb && rd_addr_wb[FLOAT_SEL_BIT];
      rf_waddr = rd_addr_wb[ADDR_W-1:0];
      rf_wdata = wb_data_wb;
    end else if (sel_fifo || sel_byp) begin
      rf_we    = !grant_req.rd[FLOAT_SEL_BIT] && !is_int_zero(grant_req.rd);
      frf_we   = grant_req.rd[FLOAT_SEL_BIT];
      rf_waddr = grant_req.rd[ADDR_W-1:0];
      rf_wdata = grant_req.data;
      clr_en   = 1'b1;
    end
  end

  wb_fifo #(.DEPTH(LU_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (lu_req),
    .pop   (sel_fifo),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Scoreboard: a new issue overrides a same-cycle retirement of the same rd.
  always_comb begin
    busy_nxt = busy;
    if (clr_en) begin
      busy_nxt[grant_req.rd] = 1'b0;
    end
    if (lu_issue && (lu_issue_rd != '0)) begin
      busy_nxt[lu_issue_rd] = 1'b1;
    end
  end

  assign sb_stall = busy[id_rs1] || busy[id_rs2] || busy[id_rs3] || busy[id_rd];

  // Counts consecutive cycles a waiting FIFO entry loses the port to the pipeline.
  always_comb begin
    starve_nxt = starve_cnt;
    if (fifo_empty || sel_fifo) begin
      starve_nxt = '0;
    end else if (sel_pipe && (starve_cnt != CNT_W'(STARVE_LIMIT))) begin
      starve_nxt = starve_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy       <= '0;
      starve_cnt <= '0;
      pipe_hold  <= 1'b0;
    end else begin
      busy       <= busy_nxt;
      starve_cnt <= starve_nxt;
      pipe_hold  <= (starve_nxt == CNT_W'(STARVE_LIMIT));
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed vector table, corner-case
// sequences and a randomized run against a queue-based reference model.
module tb_wb_port_arbiter;
  import wb_pkg::*;

  localparam int unsigned DEPTH = 2;
  localparam int unsigned LIMIT = 4;

  typedef struct packed {
    logic        wb_en;
    logic        fwb_en;
    logic [5:0]  rd;
    logic [31:0] data;
    logic        lv;
    logic [5:0]  lrd;
    logic [31:0] ldata;
    logic        iss;
    logic [5:0]  ird;
    logic [5:0]  rs1;
    logic [5:0]  rs2;
    logic [5:0]  rs3;
    logic [5:0]  drd;
    logic        we;
    logic        fwe;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        ready;
    logic        hold;
    logic        stall;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wb_en_wb = 1'b0, float_wb_en_wb = 1'b0;
  logic [5:0]  rd_addr_wb = '0;
  logic [31:0] wb_data_wb = '0;
  logic        lu_valid = 1'b0;
  logic [5:0]  lu_rd = '0;
  logic [31:0] lu_data = '0;
  logic        lu_ready;
  logic        lu_issue = 1'b0;
  logic [5:0]  lu_issue_rd = '0;
  logic [5:0]  id_rs1 = '0, id_rs2 = '0, id_rs3 = '0, id_rd = '0;
  logic        sb_stall, pipe_hold, rf_we, frf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  int checks = 0;
  int passes = 0;

  // Reference model state
  wb_req_t mq[$];
  bit      m_busy[64];
  int      m_starve;

  always #5 clk = ~clk;

  wb_port_arbiter #(.LU_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst), .wb_en_wb(wb_en_wb), .float_wb_en_wb(float_wb_en_wb),
    .rd_addr_wb(rd_addr_wb), .wb_data_wb(wb_data_wb), .lu_valid(lu_valid),
    .lu_rd(lu_rd), .lu_data(lu_data), .lu_ready(lu_ready), .lu_issue(lu_issue),
    .lu_issue_rd(lu_issue_rd), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs3(id_rs3),
    .id_rd(id_rd), .sb_stall(sb_stall), .pipe_hold(pipe_hold), .rf_we(rf_we),
    .frf_we(frf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  function automatic vec_t idle_v();
    vec_t v = '0;
    v.ready = 1'b1;
    return v;
  endfunction

  function automatic logic [5:0] rnd_rd();
    return {1'($urandom_range(0, 1)), 5'($urandom_range(0, 3))};
  endfunction

  task automatic drive(input vec_t v);
    wb_en_wb = v.wb_en;   float_wb_en_wb = v.fwb_en;
    rd_addr_wb = v.rd;    wb_data_wb = v.data;
    lu_valid = v.lv;      lu_rd = v.lrd;      lu_data = v.ldata;
    lu_issue = v.iss;     lu_issue_rd = v.ird;
    id_rs1 = v.rs1;       id_rs2 = v.rs2;     id_rs3 = v.rs3;   id_rd = v.drd;
  endtask

  task automatic check_vec(input string nm, input vec_t e);
    logic [41:0] got, exp;
    got = {rf_we, frf_we, rf_waddr, rf_wdata, lu_ready, pipe_hold, sb_stall};
    exp = {e.we, e.fwe, e.waddr, e.wdata, e.ready, e.hold, e.stall};
    if (!(e.we || e.fwe)) begin
      got[39:3] = '0;
      exp[39:3] = '0;
    end
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got we=%b fwe=%b wa=%0d wd=%h rdy=%b hold=%b stall=%b, expected we=%b fwe=%b wa=%0d wd=%h rdy=%b hold=%b stall=%b",
                  nm, rf_we, frf_we, rf_waddr, rf_wdata, lu_ready, pipe_hold, sb_stall,
                  e.we, e.fwe, e.waddr, e.wdata, e.ready, e.hold, e.stall);
  endtask

  task automatic apply(input vec_t v, input string nm);
    drive(v);
    @(negedge clk);
    check_vec(nm, v);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(idle_v());
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    mq.delete();
    foreach (m_busy[i]) m_busy[i] = 1'b0;
    m_starve = 0;
  endtask

  // Reference model: source 0 none, 1 pipeline, 2 FIFO head, 3 bypass.
  task automatic model_expect(inout vec_t v, output int src);
    wb_req_t g;
    v.hold = (m_starve == LIMIT);
    if (v.hold) src = 2;
    else if (v.wb_en || v.fwb_en) src = 1;
    else if (mq.size() > 0) src = 2;
    else if (v.lv) src = 3;
    else src = 0;
    v.we = 1'b0; v.fwe = 1'b0; v.waddr = '0; v.wdata = '0;
    if (src == 1) begin
      v.we    = v.wb_en && !v.rd[5] && (v.rd[4:0] != 0);
      v.fwe   = v.fwb_en && v.rd[5];
      v.waddr = v.rd[4:0];
      v.wdata = v.data;
    end else if (src >= 2) begin
      g = (src == 2) ? mq[0] : '{rd: v.lrd, data: v.ldata};
      v.we    = !g.rd[5] && (g.rd[4:0] != 0);
      v.fwe   = g.rd[5];
      v.waddr = g.rd[4:0];
      v.wdata = g.data;
    end
    v.ready = (mq.size() < DEPTH);
    v.stall = m_busy[v.rs1] || m_busy[v.rs2] || m_busy[v.rs3] || m_busy[v.drd];
  endtask

  task automatic model_update(input vec_t v, input int src);
    bit was_nonempty = (mq.size() > 0);
    bit can_push = v.lv && (src != 3) && ((mq.size() < DEPTH) || (src == 2));
    if (src == 2) begin
      m_busy[mq[0].rd] = 1'b0;
      void'(mq.pop_front());
    end else if (src == 3) begin
      m_busy[v.lrd] = 1'b0;
    end
    if (can_push) mq.push_back('{rd: v.lrd, data: v.ldata});
    if (v.iss && v.ird != 0) m_busy[v.ird] = 1'b1;
    m_starve = (was_nonempty && src == 1) ? m_starve + 1 : 0;
  endtask

  vec_t tbl[12];
  vec_t v;
  int   src;

  initial begin
    do_reset();

    // Directed vector table, state carried row to row from reset.
    foreach (tbl[i]) tbl[i] = idle_v();
    tbl[0].iss = 1; tbl[0].ird = 6'h05; tbl[0].rs2 = 6'h05;
    tbl[1].lv = 1; tbl[1].lrd = 6'h05; tbl[1].ldata = 32'hDEADBEEF; tbl[1].rs2 = 6'h05;
    tbl[1].we = 1; tbl[1].waddr = 5; tbl[1].wdata = 32'hDEADBEEF; tbl[1].stall = 1;
    tbl[2].rs2 = 6'h05;
    tbl[3].wb_en = 1; tbl[3].rd = 6'h03; tbl[3].data = 32'h33;
    tbl[3].lv = 1; tbl[3].lrd = 6'h24; tbl[3].ldata = 32'h44;
    tbl[3].we = 1; tbl[3].waddr = 3; tbl[3].wdata = 32'h33;
    tbl[4].fwe = 1; tbl[4].waddr = 4; tbl[4].wdata = 32'h44;
    tbl[5].fwb_en = 1; tbl[5].rd = 6'h20; tbl[5].data = 32'h55;
    tbl[5].fwe = 1; tbl[5].waddr = 0; tbl[5].wdata = 32'h55;
    tbl[6].wb_en = 1; tbl[6].rd = 6'h00; tbl[6].data = 32'h66;
    tbl[7].wb_en = 1; tbl[7].rd = 6'h21; tbl[7].data = 32'h77;
    tbl[8].iss = 1; tbl[8].ird = 6'h0A; tbl[8].rs2 = 6'h0A;
    tbl[9].lv = 1; tbl[9].lrd = 6'h0A; tbl[9].ldata = 32'hA; tbl[9].iss = 1; tbl[9].ird = 6'h0A;
    tbl[9].rs2 = 6'h0A; tbl[9].we = 1; tbl[9].waddr = 10; tbl[9].wdata = 32'hA; tbl[9].stall = 1;
    tbl[10].lv = 1; tbl[10].lrd = 6'h0A; tbl[10].ldata = 32'hAA; tbl[10].rs2 = 6'h0A;
    tbl[10].we = 1; tbl[10].waddr = 10; tbl[10].wdata = 32'hAA; tbl[10].stall = 1;
    tbl[11].rs2 = 6'h0A;
    for (int i = 0; i < 12; i++) apply(tbl[i], $sformatf("table[%0d]", i));

    // Starvation: one waiting entry, pipeline busy every cycle.
    do_reset();
    v = idle_v(); v.wb_en = 1; v.rd = 6'h01; v.data = 32'h100;
    v.lv = 1; v.lrd = 6'h22; v.ldata = 32'h99; v.we = 1; v.waddr = 1; v.wdata = 32'h100;
    apply(v, "starve_push");
    for (int i = 1; i <= 4; i++) begin
      v = idle_v(); v.wb_en = 1; v.rd = 6'h01; v.data = 32'h100 + 32'(i);
      v.we = 1; v.waddr = 1; v.wdata = 32'h100 + 32'(i);
      apply(v, $sformatf("starve_lose%0d", i));
    end
    v = idle_v(); v.wb_en = 1; v.rd = 6'h01; v.data = 32'h105;
    v.hold = 1; v.fwe = 1; v.waddr = 2; v.wdata = 32'h99;
    apply(v, "starve_hold");
    v = idle_v(); v.wb_en = 1; v.rd = 6'h01; v.data = 32'h105;
    v.we = 1; v.waddr = 1; v.wdata = 32'h105;
    apply(v, "starve_represent");
    apply(idle_v(), "starve_after");

    // Full FIFO, then pop+push while full keeps order.
    do_reset();
    v = idle_v(); v.wb_en = 1; v.rd = 6'h01; v.data = 32'h1; v.lv = 1; v.lrd = 6'h06; v.ldata = 32'h61;
    v.we = 1; v.waddr = 1; v.wdata = 32'h1; apply(v, "full_push0");
    v = idle_v(); v.wb_en = 1; v.rd = 6'h02; v.data = 32'h2; v.lv = 1; v.lrd = 6'h07; v.ldata = 32'h71;
    v.we = 1; v.waddr = 2; v.wdata = 32'h2; apply(v, "full_push1");
    v = idle_v(); v.wb_en = 1; v.rd = 6'h01; v.data = 32'h3; v.ready = 0;
    v.we = 1; v.waddr = 1; v.wdata = 32'h3; apply(v, "full_ready_low");
    v = idle_v(); v.lv = 1; v.lrd = 6'h08; v.ldata = 32'h81; v.ready = 0;
    v.we = 1; v.waddr = 6; v.wdata = 32'h61; apply(v, "full_pop_push");
    v = idle_v(); v.ready = 0; v.we = 1; v.waddr = 7; v.wdata = 32'h71; apply(v, "full_order1");
    v = idle_v(); v.we = 1; v.waddr = 8; v.wdata = 32'h81; apply(v, "full_order2");
    apply(idle_v(), "full_drained");

    // Reset asserted mid-operation with busy bits and two buffered results.
    do_reset();
    v = idle_v(); v.iss = 1; v.ird = 6'h0B; apply(v, "rst_setup0");
    v = idle_v(); v.iss = 1; v.ird = 6'h2C; v.rs1 = 6'h0B; v.stall = 1;
    v.wb_en = 1; v.rd = 6'h01; v.data = 32'h1; v.lv = 1; v.lrd = 6'h06; v.ldata = 32'h61;
    v.we = 1; v.waddr = 1; v.wdata = 32'h1; apply(v, "rst_setup1");
    v = idle_v(); v.rs2 = 6'h2C; v.stall = 1;
    v.wb_en = 1; v.rd = 6'h02; v.data = 32'h2; v.lv = 1; v.lrd = 6'h07; v.ldata = 32'h71;
    v.we = 1; v.waddr = 2; v.wdata = 32'h2; apply(v, "rst_setup2");
    v = idle_v(); v.lv = 1; v.lrd = 6'h09; v.ldata = 32'h91; v.rs1 = 6'h0B; v.rs2 = 6'h2C;
    drive(v);
    #2 rst = 1'b1;
    #1 check_vec("rst_async_outputs", idle_v());
    wb_en_wb = 1'b1; rd_addr_wb = 6'h03; wb_data_wb = 32'h33;
    v = idle_v(); v.we = 1; v.waddr = 3; v.wdata = 32'h33;
    #1 check_vec("rst_pipe_passthru", v);
    @(negedge clk);
    rst = 1'b0;
    v = idle_v(); v.rs1 = 6'h0B; v.rs2 = 6'h2C;
    drive(v);
    @(posedge clk);
    #1;
    apply(v, "rst_no_stale0");
    apply(v, "rst_no_stale1");

    // Randomized run against the reference model.
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      v = idle_v();
      v.wb_en  = ($urandom_range(0, 9) < 4);
      v.fwb_en = ($urandom_range(0, 9) < 3);
      v.rd     = rnd_rd();
      v.data   = $urandom;
      v.lv     = ($urandom_range(0, 1) == 1);
      v.lrd    = rnd_rd();
      v.ldata  = $urandom;
      v.ird    = rnd_rd();
      v.iss    = ($urandom_range(0, 3) == 0) && !m_busy[v.ird];
      v.rs1 = rnd_rd(); v.rs2 = rnd_rd(); v.rs3 = rnd_rd(); v.drd = rnd_rd();
      assert (!(v.iss && v.ird != 0 && m_busy[v.ird]))
        else $error("FAIL illegal_issue: rd=%h already busy", v.ird);
      model_expect(v, src);
      apply(v, $sformatf("random[%0d]", n));
      model_update(v, src);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Write-back port arbiter and long-latency scoreboard for the integer/float register files. Shares the single register-file write port between the in-order pipeline write-back stage (output of the MEM/WB register) and results returning from a long-latency unit (multi-cycle divider / FP unit). Buffers unit results in a small FIFO. Tracks in-flight destinations so decode can stall on RAW/WAW hazards against outstanding long-latency ops.

## Interface
Parameters:
- LU_DEPTH, 2: long-latency result FIFO depth (power of two, ≥2).
- STARVE_LIMIT, 4: consecutive cycles a non-empty FIFO may lose the port before the pipeline is held.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- wb_en_wb  in  1  pipeline integer write request.
- float_wb_en_wb  in  1  pipeline float write request.
- rd_addr_wb  in  6  pipeline destination; bit5=1 float file, bit5=0 integer file.
- wb_data_wb  in  32  pipeline write data.
- lu_valid  in  1  long-latency result valid.
- lu_rd  in  6  long-latency result destination, same encoding.
- lu_data  in  32  long-latency result data.
- lu_ready  out  1  = FIFO not full.
- lu_issue  in  1  long-latency op dispatched this cycle.
- lu_issue_rd  in  6  destination of the dispatched op.
- id_rs1, id_rs2, id_rs3, id_rd  in  6 each  decode-stage operand/destination addresses.
- sb_stall  out  1  decode must stall (operand or destination busy).
- pipe_hold  out  1  WB port granted to FIFO this cycle; pipeline must freeze MEM/WB and re-present.
- rf_we  out  1  integer file write enable.
- frf_we  out  1  float file write enable.
- rf_waddr  out  5  write address (low 5 bits of selected rd).
- rf_wdata  out  32  write data.

## Operation
- Pipeline request active = wb_en_wb | float_wb_en_wb.
- Port grant priority per cycle:
  1. pipe_hold=1 → FIFO head.
  2. Pipeline request → pipeline.
  3. FIFO non-empty → FIFO head.
  4. lu_valid with FIFO empty → direct bypass of lu_data (no push).
- lu_valid & lu_ready, not bypassed → push.
- FIFO pops when its head is granted. Push and pop in the same cycle are both allowed, including when full; lu_ready stays = !full based on registered count.
- File select: grant source's rd[5] selects frf_we vs rf_we. Pipeline path honours its individual enables. Integer writes to address 0 are suppressed (rf_we=0); the float f0 is writable.
- Scoreboard: 64-bit busy vector indexed by rd.
  - lu_issue sets busy[lu_issue_rd]; integer x0 never set.
  - A granted long-latency write (FIFO or bypass) clears busy[rd].
  - Set and clear of the same rd in one cycle → set wins.
- sb_stall = busy[id_rs1] | busy[id_rs2] | busy[id_rs3] | busy[id_rd] (combinational).
- Starvation counter (0..STARVE_LIMIT):
  - Increments when FIFO non-empty and pipeline wins the port.
  - Clears on any FIFO pop or when the FIFO is empty.
  - pipe_hold = (counter == STARVE_LIMIT).
  - While pipe_hold=1 the pipeline request is ignored; it is written in a later cycle, when re-presented.
- lu_issue to an already-busy rd is illegal: upstream prevents it via sb_stall; the bench asserts it never occurs.

## Timing
- Write-port outputs are combinational from grant; the register file commits on the next posedge. Busy-bit clear lands on that same edge.
- Bypass latency: lu_valid cycle N → file written at edge ending N.
- sb_stall reflects busy state registered at the start of the cycle. A lu_issue in cycle N stalls a dependent decode from N+1.
- pipe_hold asserts in the cycle after the STARVE_LIMIT-th lost cycle, lasts exactly one cycle, and causes a pop.
- Reset (asynchronous, mid-operation allowed):
  - FIFO emptied; busy vector cleared; counter cleared; in-flight results are discarded.
  - Outputs: pipe_hold=0, sb_stall=0, lu_ready=1, and rf_we=frf_we=0 unless a pipeline request is present.

## Structure
- Package wb_pkg:
  - typedef wb_req_t {logic [5:0] rd; logic [31:0] data;}
  - localparam FLOAT_SEL_BIT=5
  - default LU_DEPTH/STARVE_LIMIT constants.
- Sub-module wb_fifo: parameterised wb_req_t FIFO with push/pop/full/empty/head and wrap-around pointers. Arbitration, scoreboard and starvation counter stay in the top module.

## Test plan
- Bypass: FIFO empty, no pipeline request, lu_valid rd=0x05 data=0xDEADBEEF → same cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF; busy[5] cleared next cycle.
- Conflict: pipeline writes x3 while lu_valid rd=0x24 (f4) → x3 written now. f4 pushed and written the next idle cycle via frf_we with rf_waddr=4.
- Starvation: FIFO holds one entry and pipeline requests every cycle → pipe_hold=1 on the 5th cycle, FIFO entry written, pipeline write appears the following cycle.
- Full: two results pushed while pipeline busy → lu_ready=0. Simultaneous pop+push on a later cycle keeps count=2 and preserves order.
- Scoreboard: lu_issue rd=0x0A, then id_rs2=0x0A → sb_stall=1 until the cycle after the f/x10 write. Same-cycle clear+reissue of rd 0x0A keeps busy=1.
- Reset mid-operation: FIFO 2 entries, busy bits set, assert rst → lu_ready=1, sb_stall=0, pipe_hold=0, and no stale FIFO writes after release.
